if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Issues requests to a variable-latency instruction memory at the current PC and drives the IF stage's freeze and branch-redirect inputs.
- Holds a fetched instruction while the pipeline is stalled by hazards.
- Latches branch redirects that arrive while a fetch is in flight, so no branch is lost while freeze is asserted.

Parameters:
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction width
- TIMEOUT, 255, max FETCH wait cycles before err_timeout is set (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cur_pc  in  ADDR_W  IF stage PC register output (fetch address)
- Branch_taken  in  1  branch resolved taken (single-cycle pulse)
- BranchAddr  in  ADDR_W  branch target
- hazard_stall  in  1  hazard unit requests IF hold
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= cur_pc)
- imem_ready  in  1  response valid, same or later cycle
- imem_rdata  in  DATA_W  instruction data
- freeze  out  1  IF PC register hold (PC loads only when 0)
- redirect  out  1  to IF Branch_taken input
- redirect_addr  out  ADDR_W  to IF BranchAddr input
- instr_valid  out  1  instr_out valid for IF/ID
- instr_out  out  DATA_W  fetched instruction
- flush  out  1  insert bubble in IF/ID
- err_timeout  out  1  sticky timeout flag
- stall_cycles  out  16  saturating count of cycles with freeze=1

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset, including reset mid-fetch:
  - state=FETCH, br_pend=0, br_addr=0, hold_reg=0, wait_cnt=0, err_timeout=0, stall_cycles=0.
  - While rst=1: freeze=1, imem_req=0, redirect=0, instr_valid=0, instr_out=0, flush=0, redirect_addr=0.
  - The memory is reset on the same rst, so no stale response survives.
- Outputs are combinational from state, registers and current inputs.
- FETCH:
  - imem_req=1, imem_addr=cur_pc, freeze=1 unless retiring.
  - imem_ready=0 and Branch_taken=1: br_pend<=1, br_addr<=BranchAddr (newest wins). Stay in FETCH.
  - imem_ready=0: wait_cnt++ (saturating). wait_cnt==TIMEOUT sets err_timeout (sticky); state is unchanged.
  - imem_ready=1 with br_pend=1 or Branch_taken=1: data discarded. br_addr<=(Branch_taken ? BranchAddr : br_addr). Go to REDIRECT.
  - imem_ready=1 with hazard_stall=1: hold_reg<=imem_rdata, go to HOLD.
  - imem_ready=1 otherwise (retire): instr_valid=1, instr_out=imem_rdata, freeze=0. Stay in FETCH. wait_cnt<=0 on every exit/retire.
  - A zero-wait memory (ready in the request cycle) gives 1 instruction per cycle.
- HOLD:
  - imem_req=0, freeze=1, instr_valid=0.
  - Branch_taken=1: hold_reg discarded, br_addr<=BranchAddr, go to REDIRECT. Branch beats stall.
  - hazard_stall=0: instr_valid=1, instr_out=hold_reg, freeze=0, go to FETCH.
- REDIRECT (exactly 1 cycle):
  - freeze=0, redirect=1, flush=1, instr_valid=0, imem_req=0.
  - redirect_addr=(Branch_taken ? BranchAddr : br_addr). A same-cycle branch wins.
  - br_pend<=0, go to FETCH.
  - The IF PC loads the target at the end of this cycle; the next fetch uses the target.
- Branch latency: taken branch to first target request is 1 cycle from response, or from HOLD.
- stall_cycles: +1 each non-reset cycle with freeze=1; saturates at 0xFFFF.
- Branch_taken in FETCH at the same edge that reset deasserts: ignored (rst has priority).

Decomposition:
- Shared package pipeline_pkg holds:
  - fetch state enum (FETCH, HOLD, REDIRECT; 2-bit encoding)
  - ADDR_W/DATA_W defaults
  - the NOP instruction constant (32'b0, used by IF/ID on flush)
- One natural sub-module: sat_counter (width parameter, inc/clr, saturating). Instantiate it for wait_cnt (8-bit) and stall_cycles (16-bit).

Test Plan:
- Zero-wait memory, ready=1 every cycle, cur_pc 0,4,8 -> instr_valid=1 and freeze=0 each cycle; instr_out equals memory words 0..2; stall_cycles=0.
- Ready delayed 3 cycles -> freeze=1 for 3 cycles, then 1 retire cycle; stall_cycles=3.
- Branch_taken with BranchAddr=0x40 in wait cycle 1, ready in cycle 3 -> response discarded; next cycle redirect=1, redirect_addr=0x40, flush=1; following imem_addr=0x40.
- Two branches during one wait (0x40, then 0x80) -> redirect_addr=0x80.
- hazard_stall=1 at ready with data 0x00221000, released after 2 cycles -> instr_out=0x00221000 valid exactly once on release; branch arriving in HOLD instead -> held word dropped, REDIRECT.
- imem_ready held 0 for 256 cycles -> err_timeout=1, stays 1; rst=1 mid-wait -> all outputs return to reset values next cycle, br_pend cleared.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Fetch sequencer states, default widths and the bubble instruction.
package pipeline_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      HOLD     = 2'd1,
      REDIRECT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: drives imem requests, IF freeze/redirect,
// parks a fetched word across hazard stalls and latches in-flight branches.
module if_fetch_ctrl
   import pipeline_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cur_pc,
   input  logic              Branch_taken,
   input  logic [ADDR_W-1:0] BranchAddr,
   input  logic              hazard_stall,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              freeze,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_addr,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_out,
   output logic              flush,
   output logic              err_timeout,
   output logic [15:0]       stall_cycles
);

   fetch_state_t      state;
   logic              br_pend;
   logic [ADDR_W-1:0] br_addr;
   logic [DATA_W-1:0] hold_reg;
   logic [7:0]        wait_cnt;
   logic              in_fetch;
   logic              wait_inc;
   logic              wait_clr;
   logic              stall_inc;

   assign imem_addr = cur_pc;
   assign in_fetch  = (state == FETCH);
   assign wait_inc  = !rst && in_fetch && !imem_ready;
   assign wait_clr  = rst || (in_fetch && imem_ready);
   assign stall_inc = !rst && freeze;

   always_comb begin
      imem_req      = 1'b0;
      freeze        = 1'b1;
      redirect      = 1'b0;
      redirect_addr = '0;
      instr_valid   = 1'b0;
      instr_out     = DATA_W'(NOP);
      flush         = 1'b0;
      if (!rst) begin
         unique case (state)
            FETCH: begin
               imem_req = 1'b1;
               if (imem_ready && !br_pend && !Branch_taken
                   && !hazard_stall) begin
                  freeze      = 1'b0;
                  instr_valid = 1'b1;
                  instr_out   = imem_rdata;
               end
            end
            HOLD: begin
               if (!Branch_taken && !hazard_stall) begin
                  freeze      = 1'b0;
                  instr_valid = 1'b1;
                  instr_out   = hold_reg;
               end
            end
            REDIRECT: begin
               freeze   = 1'b0;
               redirect = 1'b1;
               flush    = 1'b1;
               // a branch resolving in this very cycle is the newer one
               redirect_addr = Branch_taken ? BranchAddr : br_addr;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         br_pend     <= 1'b0;
         br_addr     <= '0;
         hold_reg    <= '0;
         err_timeout <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (!imem_ready) begin
                  if (Branch_taken) begin
                     br_pend <= 1'b1;
                     br_addr <= BranchAddr;
                  end
                  if (wait_cnt == 8'(TIMEOUT)) begin
                     err_timeout <= 1'b1;
                  end
               end else if (br_pend || Branch_taken) begin
                  if (Branch_taken) begin
                     br_addr <= BranchAddr;
                  end
                  state <= REDIRECT;
               end else if (hazard_stall) begin
                  hold_reg <= imem_rdata;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (Branch_taken) begin
                  br_addr <= BranchAddr;
                  state   <= REDIRECT;
               end else if (!hazard_stall) begin
                  state <= FETCH;
               end
            end
            REDIRECT: begin
               br_pend <= 1'b0;
               state   <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

   sat_counter #(.W(8)) u_wait_cnt (
      .clk (clk),
      .clr (wait_clr),
      .inc (wait_inc),
      .q   (wait_cnt)
   );

   sat_counter #(.W(16)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (stall_inc),
      .q   (stall_cycles)
   );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level fetch model.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cur_pc = '0;
   logic        Branch_taken = 1'b0;
   logic [31:0] BranchAddr = '0;
   logic        hazard_stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        freeze;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic        flush;
   logic        err_timeout;
   logic [15:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] held_q[$];
   logic [31:0] tgt_q[$];
   bit          redir_due = 0;
   int          waited = 0;
   bit          timed_out = 0;
   int          stalled = 0;
   logic [31:0] pc_next = '0;
   bit          ovr = 0;
   logic [31:0] ovr_val = '0;

   always #5 clk = ~clk;

   if_fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .cur_pc        (cur_pc),
      .Branch_taken  (Branch_taken),
      .BranchAddr    (BranchAddr),
      .hazard_stall  (hazard_stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .freeze        (freeze),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .instr_valid   (instr_valid),
      .instr_out     (instr_out),
      .flush         (flush),
      .err_timeout   (err_timeout),
      .stall_cycles  (stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic cyc(input bit r, input bit rdy, input bit bt,
                      input logic [31:0] ba, input bit hs);
      logic e_fr, e_req, e_rd, e_v, e_fl, taken;
      logic [31:0] e_ra, e_out;
      @(negedge clk);
      cur_pc       = pc_next;
      rst          = r;
      imem_ready   = rdy;
      Branch_taken = bt;
      BranchAddr   = ba;
      hazard_stall = hs;
      imem_rdata   = ovr ? ovr_val : word_at(cur_pc);
      #1;
      e_fr = 1; e_req = 0; e_rd = 0; e_v = 0; e_fl = 0;
      e_ra = '0; e_out = '0;
      taken = bt || (tgt_q.size() != 0);
      if (!r) begin
         if (redir_due) begin
            e_fr = 0; e_rd = 1; e_fl = 1;
            e_ra = bt ? ba : tgt_q[$];
         end else if (held_q.size() != 0) begin
            if (!bt && !hs) begin
               e_fr = 0; e_v = 1; e_out = held_q[0];
            end
         end else begin
            e_req = 1;
            if (rdy && !taken && !hs) begin
               e_fr = 0; e_v = 1; e_out = imem_rdata;
            end
         end
      end
      chk("freeze", 32'(freeze), 32'(e_fr));
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("redirect", 32'(redirect), 32'(e_rd));
      chk("redirect_addr", redirect_addr, e_ra);
      chk("instr_valid", 32'(instr_valid), 32'(e_v));
      chk("instr_out", instr_out, e_out);
      chk("flush", 32'(flush), 32'(e_fl));
      if (e_req) chk("imem_addr", imem_addr, cur_pc);
      if (!r) begin
         chk("err_timeout", 32'(err_timeout), 32'(timed_out));
         chk("stall_cycles", 32'(stall_cycles), 32'(stalled));
      end
      if (r) pc_next = '0;
      else if (!e_fr) pc_next = e_rd ? e_ra : cur_pc + 32'd4;
      else pc_next = cur_pc;
      @(posedge clk);
      if (r) begin
         held_q.delete(); tgt_q.delete();
         redir_due = 0; waited = 0; timed_out = 0; stalled = 0;
      end else begin
         if (e_fr && stalled < 65535) stalled++;
         if (redir_due) begin
            redir_due = 0;
            tgt_q.delete();
         end else if (held_q.size() != 0) begin
            if (bt) begin
               held_q.delete();
               tgt_q.push_back(ba);
               redir_due = 1;
            end else if (!hs) begin
               held_q.delete();
            end
         end else if (!rdy) begin
            if (bt) tgt_q.push_back(ba);
            if (waited == 255) timed_out = 1;
            if (waited < 255) waited++;
         end else begin
            waited = 0;
            if (taken) begin
               if (bt) tgt_q.push_back(ba);
               redir_due = 1;
            end else if (hs) begin
               held_q.push_back(imem_rdata);
            end
         end
      end
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 32'h44, 0);
      // zero-wait memory
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
      chk("zero_wait_stalls", 32'(stall_cycles), 32'd0);
      // three wait cycles then retire
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("delay_stalls", 32'(stall_cycles), 32'd3);
      // branch during wait, response discarded
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h40, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      // two branches in one wait, newest wins
      cyc(0, 0, 1, 32'h40, 0);
      cyc(0, 0, 1, 32'h80, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      // hazard hold then release
      ovr = 1; ovr_val = 32'h0022_1000;
      cyc(0, 1, 0, 0, 1);
      ovr = 0;
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      // branch beats stall in hold
      cyc(0, 1, 0, 0, 1);
      cyc(0, 0, 1, 32'h100, 1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      // timeout and stickiness
      for (int i = 0; i < 260; i++) cyc(0, 0, 0, 0, 0);
      chk("timeout_set", 32'(err_timeout), 32'd1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      // reset mid-wait with a pending branch
      cyc(0, 0, 1, 32'h200, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      // random traffic at several mixes
      for (int ph = 0; ph < 4; ph++) begin
         int p_rdy, p_bt, p_hs;
         p_rdy = (ph == 0) ? 90 : (ph == 1) ? 40 : (ph == 2) ? 70 : 20;
         p_bt  = (ph == 3) ? 30 : 12;
         p_hs  = (ph == 2) ? 50 : 20;
         for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 99) < p_rdy),
                ($urandom_range(0, 99) < p_bt),
                {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                ($urandom_range(0, 99) < p_hs));
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
